// File: rtl/reg_bus_file.sv
// General-purpose register file with an integrated bus source multiplexer.
// The top register can act as a program counter with a hardware increment.
// A sticky flag records any clock edge at which more than one bus source was enabled.
module reg_bus_file #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PC_EN = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       din,
  input  logic [WIDTH-1:0]       g,
  input  logic [NREGS-1:0]       rin,
  input  logic [NREGS-1:0]       rout,
  input  logic                   gout,
  input  logic                   dinout,
  input  logic                   incr_pc,
  input  logic                   err_clr,
  output logic [WIDTH-1:0]       bus,
  output logic [WIDTH*NREGS-1:0] regs_flat,
  output logic                   sel_err
);

  generate
    if (NREGS < 2 || NREGS > 16) begin : g_bad_nregs
      $error("reg_bus_file: NREGS must be in 2..16");
    end
  endgenerate

  logic [WIDTH-1:0] regs [NREGS];
  logic [4:0]       src_count;
  logic             multi_src;

  // Bus mux with fixed priority.
  // The register loop runs from the top index down, so the lowest enabled rout wins.
  // g overrides any register, and din overrides everything.
  always_comb begin
    bus = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (rout[i]) bus = regs[i];
    end
    if (gout)   bus = g;
    if (dinout) bus = din;
  end

  // Count the enabled bus sources to detect a drive conflict.
  always_comb begin
    src_count = 5'(gout) + 5'(dinout);
    for (int i = 0; i < NREGS; i++) begin
      src_count = src_count + 5'(rout[i]);
    end
    multi_src = (src_count > 5'd1);
  end

  // Register loads from the bus, and the PC increment.
  // A register that is both driving and loading keeps its value.
  // A load of the PC takes precedence over the increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (rin[i]) begin
          if (!rout[i]) regs[i] <= bus;
        end else if (i == NREGS - 1 && PC_EN != 0 && incr_pc) begin
          regs[i] <= regs[i] + WIDTH'(1);
        end
      end
    end
  end

  // Sticky conflict flag. Setting the flag wins over clearing it in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          sel_err <= 1'b0;
    else if (multi_src) sel_err <= 1'b1;
    else if (err_clr)   sel_err <= 1'b0;
  end

  generate
    for (genvar i = 0; i < NREGS; i++) begin : g_flat
      assign regs_flat[WIDTH*i +: WIDTH] = regs[i];
    end
  endgenerate

endmodule

// File: tb/tb_reg_bus_file.sv
// Self-checking bench for reg_bus_file: table vectors plus an expectation queue,
// and hand-written reset sequences. A second instance built with PC_EN=0 shares the stimulus.
module tb_reg_bus_file;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] din, g;
  logic [7:0]  rin, rout;
  logic        gout, dinout, incr_pc, err_clr;
  logic [15:0] bus, bus_b;
  logic [127:0] regs_flat, regs_flat_b;
  logic        sel_err, sel_err_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  reg_bus_file #(.WIDTH(16), .NREGS(8), .PC_EN(1)) dut (
    .clock(clock), .reset(reset), .din(din), .g(g), .rin(rin), .rout(rout),
    .gout(gout), .dinout(dinout), .incr_pc(incr_pc), .err_clr(err_clr),
    .bus(bus), .regs_flat(regs_flat), .sel_err(sel_err)
  );

  reg_bus_file #(.WIDTH(16), .NREGS(8), .PC_EN(0)) dut_nopc (
    .clock(clock), .reset(reset), .din(din), .g(g), .rin(rin), .rout(rout),
    .gout(gout), .dinout(dinout), .incr_pc(incr_pc), .err_clr(err_clr),
    .bus(bus_b), .regs_flat(regs_flat_b), .sel_err(sel_err_b)
  );

  typedef struct {
    logic [15:0] din;
    logic [15:0] g;
    logic [7:0]  rin;
    logic [7:0]  rout;
    logic        gout;
    logic        dinout;
    logic        incr;
    logic        clr;
    logic [15:0] bus;
    int          idx;
    logic [15:0] val;
    logic        err;
    logic        chkb;
    logic [15:0] valb;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] val;
    logic        err;
    logic        chkb;
    logic [15:0] valb;
    int          num;
  } exp_t;

  localparam int NV = 20;
  vec_t vecs [NV];
  exp_t sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    din = 16'h0; g = 16'h0; rin = 8'h0; rout = 8'h0;
    gout = 1'b0; dinout = 1'b0; incr_pc = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    exp_t e;

    //         din      g        rin    rout   go dio inc clr bus      idx val      err chkb valb
    vecs[0]  = '{16'h1234, 16'h0000, 8'h04, 8'h00, 0, 1, 0, 0, 16'h1234, 2, 16'h1234, 0, 0, 16'h0};
    vecs[1]  = '{16'h0000, 16'h0000, 8'h20, 8'h04, 0, 0, 0, 0, 16'h1234, 5, 16'h1234, 0, 0, 16'h0};
    vecs[2]  = '{16'h0000, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0000, 2, 16'h1234, 0, 0, 16'h0};
    vecs[3]  = '{16'h0001, 16'h0000, 8'h01, 8'h00, 0, 1, 0, 0, 16'h0001, 0, 16'h0001, 0, 0, 16'h0};
    vecs[4]  = '{16'h0000, 16'hAAAA, 8'h00, 8'h01, 1, 0, 0, 0, 16'hAAAA, 0, 16'h0001, 1, 0, 16'h0};
    vecs[5]  = '{16'h0000, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0000, 0, 16'h0001, 1, 0, 16'h0};
    vecs[6]  = '{16'h0000, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 1, 16'h0000, 0, 16'h0001, 0, 0, 16'h0};
    vecs[7]  = '{16'h5555, 16'hAAAA, 8'h00, 8'h00, 1, 1, 0, 1, 16'h5555, 0, 16'h0001, 1, 0, 16'h0};
    vecs[8]  = '{16'h0000, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 1, 16'h0000, 0, 16'h0001, 0, 0, 16'h0};
    vecs[9]  = '{16'h0000, 16'h0000, 8'h00, 8'h02, 0, 0, 0, 0, 16'h0000, 1, 16'h0000, 0, 0, 16'h0};
    vecs[10] = '{16'hFFFE, 16'h0000, 8'h80, 8'h00, 0, 1, 0, 0, 16'hFFFE, 7, 16'hFFFE, 0, 0, 16'h0};
    vecs[11] = '{16'h0000, 16'h0000, 8'h00, 8'h00, 0, 0, 1, 0, 16'h0000, 7, 16'hFFFF, 0, 0, 16'h0};
    vecs[12] = '{16'h0000, 16'h0000, 8'h00, 8'h00, 0, 0, 1, 0, 16'h0000, 7, 16'h0000, 0, 0, 16'h0};
    vecs[13] = '{16'h0000, 16'h0000, 8'h00, 8'h00, 0, 0, 1, 0, 16'h0000, 7, 16'h0001, 0, 1, 16'hFFFE};
    vecs[14] = '{16'h0040, 16'h0000, 8'h80, 8'h00, 0, 1, 1, 0, 16'h0040, 7, 16'h0040, 0, 0, 16'h0};
    vecs[15] = '{16'h0010, 16'h0000, 8'h80, 8'h00, 0, 1, 0, 0, 16'h0010, 7, 16'h0010, 0, 0, 16'h0};
    vecs[16] = '{16'h0000, 16'h0000, 8'h08, 8'h80, 0, 0, 1, 0, 16'h0010, 7, 16'h0011, 0, 1, 16'h0010};
    vecs[17] = '{16'h0000, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0000, 3, 16'h0010, 0, 0, 16'h0};
    vecs[18] = '{16'h0000, 16'h0000, 8'h04, 8'h04, 0, 0, 0, 0, 16'h1234, 2, 16'h1234, 0, 0, 16'h0};
    vecs[19] = '{16'h00FF, 16'h0000, 8'h03, 8'h00, 0, 1, 0, 0, 16'h00FF, 1, 16'h00FF, 0, 0, 16'h0};

    idle_inputs();
    reset = 1'b1;
    #2;
    chk("reset_regs_zero", 32'(regs_flat == 128'h0), 32'h1);
    chk("reset_bus", 32'(bus), 32'h0);
    chk("reset_sel_err", 32'(sel_err), 32'h0);

    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock);
      #1;
      chk("idle_regs_zero", 32'(regs_flat == 128'h0), 32'h1);
      chk("idle_bus", 32'(bus), 32'h0);
      chk("idle_sel_err", 32'(sel_err), 32'h0);
    end

    for (int v = 0; v < NV; v++) begin
      din = vecs[v].din; g = vecs[v].g; rin = vecs[v].rin; rout = vecs[v].rout;
      gout = vecs[v].gout; dinout = vecs[v].dinout; incr_pc = vecs[v].incr; err_clr = vecs[v].clr;
      #1;
      chk($sformatf("vec%0d_bus", v), 32'(bus), 32'(vecs[v].bus));
      sb.push_back('{vecs[v].idx, vecs[v].val, vecs[v].err, vecs[v].chkb, vecs[v].valb, v});
      @(posedge clock);
      #1;
      e = sb.pop_front();
      chk($sformatf("vec%0d_r%0d", e.num, e.idx), 32'(regs_flat[16*e.idx +: 16]), 32'(e.val));
      chk($sformatf("vec%0d_sel_err", e.num), 32'(sel_err), 32'(e.err));
      if (e.chkb)
        chk($sformatf("vec%0d_nopc_r7", e.num), 32'(regs_flat_b[16*7 +: 16]), 32'(e.valb));
    end
    idle_inputs();
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    // Load R1..R4 with a nonzero value, then pulse reset between edges during a load of all registers.
    din = 16'hBEEF; dinout = 1'b1; rin = 8'h1E;
    @(posedge clock);
    #1;
    chk("pre_reset_r4", 32'(regs_flat[16*4 +: 16]), 32'hBEEF);
    din = 16'h7777; rin = 8'hFF;
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_regs", 32'(regs_flat == 128'h0), 32'h1);
    chk("async_reset_nopc_regs", 32'(regs_flat_b == 128'h0), 32'h1);
    chk("async_reset_bus", 32'(bus), 32'h7777);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("post_reset_load_all", 32'(regs_flat == {8{16'h7777}}), 32'h1);
    chk("post_reset_sel_err", 32'(sel_err), 32'h0);
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
